// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the PC, runs the fetch/exec handshake with instruction memory, and keeps the jsb/ret return stack.
module pc_sequencer #(
  parameter int PC_W        = 12,
  parameter int INSTR_W     = 18,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [PC_W-1:0]    pc_o,
  input  logic [PC_W-1:0]    next_pc_i,
  input  logic               update_i,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [PC_W-1:0]    ret_addr_o,
  output logic               stack_empty_o,
  output logic               stack_full_o,
  output logic               overflow_o,
  output logic               underflow_o
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {FETCH, EXEC, ERROR} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] pc, pc_inc, stack [STACK_DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] top_idx;
  logic commit, err_ovf, err_udf, legal;
  assign top_idx       = AW'(count - CW'(1));
  assign pc_inc        = pc + PC_W'(1);
  assign commit        = state == EXEC && update_i;
  assign err_ovf       = commit && push_i && !pop_i && stack_full_o;
  assign err_udf       = commit && pop_i && stack_empty_o;
  assign legal         = commit && !err_ovf && !err_udf;
  assign pc_o          = pc;
  assign imem_addr_o   = pc;
  assign imem_req_o    = state == FETCH;
  assign instr_valid_o = state == EXEC;
  assign stack_empty_o = count == '0;
  assign stack_full_o  = count == CW'(STACK_DEPTH);
  assign ret_addr_o    = stack_empty_o ? '0 : stack[top_idx];
  always_comb begin
    state_nx = state == FETCH ? (imem_ack_i ? EXEC : FETCH) :
               state == EXEC  ? (err_ovf || err_udf ? ERROR : commit ? FETCH : EXEC) : ERROR;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= FETCH;
      pc          <= '0;
      instr_o     <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_ack_i) instr_o <= imem_data_i;
      if (err_ovf) overflow_o <= 1'b1;
      if (err_udf) underflow_o <= 1'b1;
      if (legal) begin
        pc <= pop_i ? stack[top_idx] : next_pc_i;
        if (push_i && !pop_i) count <= count + CW'(1);
        else if (pop_i && !push_i) count <= count - CW'(1);
      end
    end
  end
  // push+pop overwrites the current top in place; a plain push writes just above it
  always_ff @(posedge clk_i) begin
    if (legal && push_i) stack[pop_i ? top_idx : AW'(count)] <= pc_inc;
  end
endmodule
